// File: rtl/tone_osc_bank.sv
// Multi-voice square-wave tone generator with glitch-free note updates
// and a registered count of voices currently high for the mixer.
module tone_osc_bank #(
    parameter int NUM_VOICES  = 4,
    parameter int CLOCK_SPEED = 25_000_000,
    parameter int OCT_W       = 2,
    parameter int CNT_W       = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [4*NUM_VOICES-1:0]             tone,
    input  logic [OCT_W*NUM_VOICES-1:0]         octave,
    output logic [NUM_VOICES-1:0]               wave_out,
    output logic [NUM_VOICES-1:0]               active,
    output logic [$clog2(NUM_VOICES+1)-1:0]     mix_out
);

    localparam int MIX_W = $clog2(NUM_VOICES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    function automatic logic [63:0] base_half(input int code);
        logic [63:0] b;
        case (code)
            1:       b = 64'd41844;
            2:       b = 64'd37278;
            3:       b = 64'd35186;
            4:       b = 64'd31347;
            5:       b = 64'd27927;
            6:       b = 64'd26360;
            7:       b = 64'd23484;
            8:       b = 64'd20922;
            9:       b = 64'd18639;
            10:      b = 64'd17593;
            11:      b = 64'd15674;
            12:      b = 64'd13964;
            13:      b = 64'd13180;
            14:      b = 64'd11742;
            15:      b = 64'd10461;
            default: b = 64'd0;
        endcase
        return b;
    endfunction

    function automatic logic [CNT_W-1:0] scaled_half(input int code);
        logic [63:0] p;
        p = base_half(code) * 64'(CLOCK_SPEED) / 64'd25_000_000;
        return p[CNT_W-1:0];
    endfunction

    // Table is fully resolved at elaboration; only the octave shift is live logic.
    localparam logic [CNT_W-1:0] HALF [16] = '{
        scaled_half(0),  scaled_half(1),  scaled_half(2),  scaled_half(3),
        scaled_half(4),  scaled_half(5),  scaled_half(6),  scaled_half(7),
        scaled_half(8),  scaled_half(9),  scaled_half(10), scaled_half(11),
        scaled_half(12), scaled_half(13), scaled_half(14), scaled_half(15)
    };

    function automatic logic [CNT_W-1:0] eff_half(
        input logic [3:0]       code,
        input logic [OCT_W-1:0] oct
    );
        logic [CNT_W-1:0] h;
        h = HALF[code] >> oct;
        if (h == '0) begin
            h = CNT_W'(1);
        end
        return h;
    endfunction

    logic [0:0]            state_q [NUM_VOICES];
    logic [0:0]            state_d [NUM_VOICES];
    logic [CNT_W-1:0]      cnt_q   [NUM_VOICES];
    logic [CNT_W-1:0]      cnt_d   [NUM_VOICES];
    logic [CNT_W-1:0]      h_q     [NUM_VOICES];
    logic [CNT_W-1:0]      h_d     [NUM_VOICES];
    logic [NUM_VOICES-1:0] wave_q;
    logic [NUM_VOICES-1:0] wave_d;
    logic [MIX_W-1:0]      mix_q;
    logic [MIX_W-1:0]      mix_d;

    always_comb begin
        logic [3:0]       tone_v;
        logic [OCT_W-1:0] oct_v;
        tone_v = '0;
        oct_v  = '0;
        wave_d = wave_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            state_d[v] = state_q[v];
            cnt_d[v]   = cnt_q[v];
            h_d[v]     = h_q[v];
            tone_v     = tone[4*v +: 4];
            oct_v      = octave[OCT_W*v +: OCT_W];
            if (enable) begin
                unique case (state_q[v])
                    ST_IDLE: begin
                        cnt_d[v]  = '0;
                        wave_d[v] = 1'b0;
                        if (tone_v != 4'd0) begin
                            state_d[v] = ST_RUN;
                            h_d[v]     = eff_half(tone_v, oct_v);
                        end
                    end
                    default: begin
                        if (cnt_q[v] == h_q[v] - CNT_W'(1)) begin
                            cnt_d[v]  = '0;
                            wave_d[v] = ~wave_q[v];
                            // Falling edge closes a full cycle: only here may the note change.
                            if (wave_q[v]) begin
                                if (tone_v == 4'd0) begin
                                    state_d[v] = ST_IDLE;
                                end else begin
                                    h_d[v] = eff_half(tone_v, oct_v);
                                end
                            end
                        end else begin
                            cnt_d[v] = cnt_q[v] + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_comb begin
        logic [MIX_W-1:0] sum;
        sum = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            sum = sum + MIX_W'(wave_q[v]);
        end
        mix_d = enable ? sum : mix_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= ST_IDLE;
                cnt_q[v]   <= '0;
                h_q[v]     <= '0;
            end
            wave_q <= '0;
            mix_q  <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                state_q[v] <= state_d[v];
                cnt_q[v]   <= cnt_d[v];
                h_q[v]     <= h_d[v];
            end
            wave_q <= wave_d;
            mix_q  <= mix_d;
        end
    end

    always_comb begin
        active = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            active[v] = (state_q[v] == ST_RUN);
        end
    end

    assign wave_out = wave_q;
    assign mix_out  = mix_q;

endmodule
